vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit, the single system clock (100 MHz board clock).
REQ-010 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-011 SHALL have port pix_en, input, 1 bit, pixel-rate enable, i.e. the clk_divider output (one clk-cycle pulse per pixel).
REQ-012 SHALL have port hsync, output, 1 bit, horizontal sync, active low.
REQ-013 SHALL have port vsync, output, 1 bit, vertical sync, active low.
REQ-014 SHALL have port video_on, output, 1 bit, high inside the visible region.
REQ-015 SHALL have port x, output, 10 bits, current horizontal pixel count.
REQ-016 SHALL have port y, output, 10 bits, current line count.
REQ-017 SHALL have port frame_start, output, 1 bit, one-clk pulse at frame origin.

Function
REQ-018 SHALL use one clock domain only: all registers clocked on posedge clk, advancing only when pix_en=1; pix_en is never used as a clock.
REQ-019 SHALL derive H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 SHALL increment x by 1 on each pix_en; at x=H_TOTAL-1 it wraps to 0 on the next pix_en.
REQ-021 SHALL increment y by 1 only on the pix_en where x wraps; at y=V_TOTAL-1 with x wrapping, y wraps to 0.
REQ-022 SHALL hold x and y unchanged on cycles with pix_en=0, including arbitrarily long gaps.
REQ-023 SHALL implement the horizontal phase FSM H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT, changing state only on pix_en at x = H_VISIBLE-1, H_VISIBLE+H_FRONT-1, H_VISIBLE+H_FRONT+H_SYNC-1 and H_TOTAL-1 respectively.
REQ-024 SHALL implement the vertical FSM V_ACT -> V_FP -> V_SYN -> V_BP -> V_ACT with the same rule using the V_* parameters, evaluated only at line wrap.
REQ-025 SHALL drive hsync=0 exactly while the H FSM is in H_SYN (x in 656..751 by default), else 1.
REQ-026 SHALL drive vsync=0 exactly while the V FSM is in V_SYN (y in 490..491 by default), else 1.
REQ-027 SHALL drive video_on=1 iff H FSM = H_ACT and V FSM = V_ACT.
REQ-028 SHALL decode hsync, vsync and video_on only from registers, with no combinational path from pix_en or rst to any output.
REQ-029 SHALL assert frame_start for exactly one clk cycle, on the cycle after the pix_en that moves (x,y) from (H_TOTAL-1,V_TOTAL-1) to (0,0).

Reset
REQ-030 SHALL, on a clk edge with rst=1, set x=0, y=0, H_ACT, V_ACT and frame_start=0, giving hsync=1, vsync=1 and video_on=1 in the following cycle.
REQ-031 SHALL give rst priority over pix_en, and a reset asserted mid-line or mid-sync SHALL abort the frame and restart at (0,0) with no frame_start pulse.

Structure
REQ-032 SHALL take the default timing constants and the FSM state encodings (2-bit) from the shared package vga_timing_pkg, which the future pixel generator also uses.
REQ-033 SHALL contain no sub-modules; the clk_divider is instantiated beside this block at top level and drives pix_en.

Verification
REQ-034 The bench SHALL cover reset then 800 pix_en pulses -> x runs 0..799 and back to 0, y increments 0 to 1 exactly once.
REQ-035 The bench SHALL cover one line at default parameters -> hsync low for exactly 96 pix_en, first low at x=656, high again at x=752.
REQ-036 The bench SHALL cover one full frame (420000 pix_en) -> vsync low for lines 490-491 only, video_on high for exactly 307200 pix_en, and one frame_start pulse one clk after the (799,524)->(0,0) wrap.
REQ-037 The bench SHALL cover pix_en held 0 for 50 clks at x=655 -> x, y, hsync and frame_start are unchanged throughout.
REQ-038 The bench SHALL cover rst pulsed for one clk at (700,491) with vsync low -> the next cycle shows x=0, y=0, hsync=1, vsync=1, video_on=1, frame_start=0.
REQ-039 The bench SHALL cover pix_en driven by a real clk_divider instance (25 MHz from 100 MHz) -> the measured hsync period is 3200 clk cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants and the
// 2-bit phase encodings used by the sync generator and the pixel generator.
`timescale 1ns/1ps
package vga_timing_pkg;

  // Default horizontal timing, in pixels.
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Horizontal phase within a line.
  typedef enum logic [1:0] {
    H_ACT = 2'd0,
    H_FP  = 2'd1,
    H_SYN = 2'd2,
    H_BP  = 2'd3
  } h_state_t;

  // Vertical phase within a frame.
  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FP  = 2'd1,
    V_SYN = 2'd2,
    V_BP  = 2'd3
  } v_state_t;

  // Total length of one axis (line or frame) from its four phase lengths.
  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// VGA sync generator: x/y raster counters advanced by a pixel-rate enable,
// horizontal and vertical phase FSMs, and sync/blanking decode.
// x and y are 10 bits wide, so each axis total must not exceed 1024.
`timescale 1ns/1ps
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Last position of each phase; the FSMs leave a phase on the pixel/line
  // enable that occurs while sitting on that position.
  localparam logic [9:0] H_ACT_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] H_SYN_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_ACT_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] V_SYN_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  h_state_t h_state;
  v_state_t v_state;

  logic line_end;   // this pixel enable wraps x
  logic frame_end;  // this pixel enable wraps both x and y

  assign line_end  = pix_en && (x == H_LAST);
  assign frame_end = line_end && (y == V_LAST);

  // Raster counters and the frame origin pulse; reset wins over pix_en.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    if (rst) begin
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      // Pulse lasts one clk: it is re-evaluated (and normally cleared) every
      // cycle, not only on pixel enables.
      frame_start <= frame_end;
      if (pix_en) begin
        if (line_end) begin
          x <= '0;
          y <= (y == V_LAST) ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Horizontal phase FSM, stepping only on the pixel enable at phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_state <= H_ACT;
    end else if (pix_en) begin
      // NOTE: the default arm keeps the case fully specified so no state is
      // left undefined, even though all four 2-bit codes are named.
      case (h_state)
        H_ACT:   if (x == H_ACT_LAST) h_state <= H_FP;
        H_FP:    if (x == H_FP_LAST)  h_state <= H_SYN;
        H_SYN:   if (x == H_SYN_LAST) h_state <= H_BP;
        H_BP:    if (x == H_LAST)     h_state <= H_ACT;
        default: h_state <= H_ACT;
      endcase
    end
  end

  // Vertical phase FSM, stepping only at line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_state <= V_ACT;
    end else if (line_end) begin
      case (v_state)
        V_ACT:   if (y == V_ACT_LAST) v_state <= V_FP;
        V_FP:    if (y == V_FP_LAST)  v_state <= V_SYN;
        V_SYN:   if (y == V_SYN_LAST) v_state <= V_BP;
        V_BP:    if (y == V_LAST)     v_state <= V_ACT;
        default: v_state <= V_ACT;
      endcase
    end
  end

  // Outputs decode the phase registers only, so they never see pix_en or rst
  // combinationally and change exactly when x/y change.
  assign hsync    = (h_state != H_SYN);
  assign vsync    = (v_state != V_SYN);
  assign video_on = (h_state == H_ACT) && (v_state == V_ACT);

endmodule
